// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM state encoding and the counter-width helper.
package seq_multiplier_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Smallest r with 2**r >= value; used for the iteration counter width.
    function automatic int clog2(input int value);
        int r;
        for (r = 0; (32'sd1 <<< r) < value; r++) begin
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_multiplier_cond_adder.sv
// Conditional partial-product adder: S = EN ? A + B : B.
module cond_adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         EN,
    output logic [W-1:0] S
);

    assign S = EN ? (A + B) : B;

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier, unsigned or two's-complement per operation,
// one partial product per clock with Start/Busy/Done handshake and optional early exit.
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int EARLY_EXIT = 0
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Signed,
    input  logic [WIDTH-1:0]   Xin,
    input  logic [WIDTH-1:0]   Yin,
    output logic               Busy,
    output logic               Done,
    output logic [2*WIDTH-1:0] M
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = clog2(WIDTH);

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [PW-1:0]   r_x;
    logic [WIDTH-1:0] r_y;
    logic [PW-1:0]   r_acc;
    logic            r_sign;
    logic [PW-1:0]   r_m;
    logic            r_busy;
    logic            r_done;

    logic [WIDTH-1:0] w_xin_mag;
    logic [WIDTH-1:0] w_yin_mag;
    logic [PW-1:0]    w_acc_next;
    logic [PW-1:0]    w_prod;
    logic             w_last;

    // |-2^(W-1)| wraps to the same bit pattern, which is the correct unsigned magnitude.
    assign w_xin_mag = (Signed && Xin[WIDTH-1]) ? (-Xin) : Xin;
    assign w_yin_mag = (Signed && Yin[WIDTH-1]) ? (-Yin) : Yin;

    cond_adder #(.W(PW)) u_cond_adder (
        .A  (r_x),
        .B  (r_acc),
        .EN (r_y[0]),
        .S  (w_acc_next)
    );

    assign w_last = (r_cnt == CW'(WIDTH - 1)) ||
                    ((EARLY_EXIT != 0) && (r_y[WIDTH-1:1] == '0));
    assign w_prod = r_sign ? (-w_acc_next) : w_acc_next;

    assign Busy = r_busy;
    assign Done = r_done;
    assign M    = r_m;

    // Control FSM, shift/accumulate datapath and result register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_acc   <= '0;
            r_sign  <= 1'b0;
            r_m     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (Start) begin
                        r_state <= ST_RUN;
                        r_sign  <= Signed & (Xin[WIDTH-1] ^ Yin[WIDTH-1]);
                        r_x     <= {{WIDTH{1'b0}}, w_xin_mag};
                        r_y     <= w_yin_mag;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_acc <= w_acc_next;
                    r_x   <= r_x << 1;
                    r_y   <= r_y >> 1;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_m     <= w_prod;
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench: a 4-bit fixed-latency instance and an 8-bit early-exit instance
// share one clock; monitors pop expected products whenever Done is seen.
module tb_seq_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start4, sig4;
    logic [3:0]  x4, y4;
    logic        busy4, done4;
    logic [7:0]  m4;
    logic        start8, sig8;
    logic [7:0]  x8, y8;
    logic        busy8, done8;
    logic [15:0] m8;

    int errors = 0;
    int checks = 0;
    int done4_cnt = 0;
    int done8_cnt = 0;
    int issued8 = 0;
    logic [7:0]  q4[$];
    logic [15:0] q8[$];
    logic [7:0]  exp4;
    logic [15:0] exp8;

    seq_multiplier #(.WIDTH(4), .EARLY_EXIT(0)) dut4 (
        .Clk(clk), .Reset(rst), .Start(start4), .Signed(sig4),
        .Xin(x4), .Yin(y4), .Busy(busy4), .Done(done4), .M(m4)
    );

    seq_multiplier #(.WIDTH(8), .EARLY_EXIT(1)) dut8 (
        .Clk(clk), .Reset(rst), .Start(start8), .Signed(sig8),
        .Xin(x8), .Yin(y8), .Busy(busy8), .Done(done8), .M(m8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // 4-bit monitor
    always @(negedge clk) begin
        if (done4 === 1'b1) begin
            done4_cnt++;
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut4_unexpected_done: got M=%0h, required no Done", m4);
            end else begin
                exp4 = q4.pop_front();
                check("dut4_product", {24'd0, m4}, {24'd0, exp4});
            end
            check("dut4_busy_in_done", {31'd0, busy4}, 32'd0);
        end
    end

    // 8-bit monitor
    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            done8_cnt++;
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut8_unexpected_done: got M=%0h, required no Done", m8);
            end else begin
                exp8 = q8.pop_front();
                check("dut8_product", {16'd0, m8}, {16'd0, exp8});
            end
            check("dut8_busy_in_done", {31'd0, busy8}, 32'd0);
        end
    end

    task automatic run4(input logic s, input logic [3:0] x, input logic [3:0] y,
                        input logic [7:0] exp);
        int n;
        int busy_n;
        sig4 = s; x4 = x; y4 = y; start4 = 1'b1;
        q4.push_back(exp);
        tick();
        start4 = 1'b0;
        x4 = 4'($urandom); y4 = 4'($urandom); sig4 = ~s;
        n = 0; busy_n = 0;
        while (n < 20) begin
            if (busy4) busy_n++;
            tick();
            n++;
            if (done4) break;
        end
        check("dut4_latency", n, 32'd4);
        check("dut4_busy_cycles", busy_n, 32'd4);
    endtask

    task automatic run8(input logic s, input logic [7:0] x, input logic [7:0] y,
                        input logic [15:0] exp, input int lat);
        int n;
        int busy_n;
        sig8 = s; x8 = x; y8 = y; start8 = 1'b1;
        q8.push_back(exp);
        issued8++;
        tick();
        start8 = 1'b0;
        x8 = 8'($urandom); y8 = 8'($urandom); sig8 = ~s;
        n = 0; busy_n = 0;
        while (n < 20) begin
            if (busy8) busy_n++;
            tick();
            n++;
            if (done8) break;
        end
        check("dut8_latency", n, lat);
        check("dut8_busy_cycles", busy_n, lat);
    endtask

    function automatic logic [15:0] ref8(input logic s, input logic [7:0] x, input logic [7:0] y);
        int p;
        if (s) p = int'($signed(x)) * int'($signed(y));
        else   p = int'(x) * int'(y);
        return 16'(p);
    endfunction

    function automatic int lat8(input logic s, input logic [7:0] y);
        logic [7:0] mag;
        int l;
        mag = (s && y[7]) ? 8'(-y) : y;
        l = 1;
        for (int i = 0; i < 8; i++) if (mag[i]) l = i + 1;
        return l;
    endfunction

    initial begin
        int saved;
        logic s;
        logic [7:0] rx, ry;
        rst = 1'b1;
        start4 = 1'b0; sig4 = 1'b0; x4 = 4'd0; y4 = 4'd0;
        start8 = 1'b0; sig8 = 1'b0; x8 = 8'd0; y8 = 8'd0;
        repeat (2) tick();
        check("reset_busy4", {31'd0, busy4}, 32'd0);
        check("reset_done4", {31'd0, done4}, 32'd0);
        check("reset_m4", {24'd0, m4}, 32'd0);
        check("reset_busy8", {31'd0, busy8}, 32'd0);
        check("reset_m8", {16'd0, m8}, 32'd0);
        rst = 1'b0;
        tick();

        // Unsigned max and signed corners
        run4(1'b0, 4'd15, 4'd15, 8'd225);
        tick();
        run4(1'b1, 4'b1000, 4'd7, 8'hC8);
        run4(1'b1, 4'b1000, 4'b1000, 8'h40);
        run4(1'b1, 4'd7, 4'b1111, 8'hF9);
        tick();

        // Start held high through RUN with new operands must be ignored
        sig4 = 1'b0; x4 = 4'd3; y4 = 4'd5; start4 = 1'b1;
        q4.push_back(8'd15);
        tick();
        x4 = 4'd1; y4 = 4'd1;
        saved = 0;
        while (saved < 20) begin
            tick();
            saved++;
            if (done4) break;
        end
        check("dut4_held_start_latency", saved, 32'd4);
        run4(1'b0, 4'd2, 4'd7, 8'd14);
        tick();

        // Reset in the middle of 9*9 aborts it
        sig4 = 1'b0; x4 = 4'd9; y4 = 4'd9; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy4", {31'd0, busy4}, 32'd0);
        check("abort_done4", {31'd0, done4}, 32'd0);
        check("abort_m4", {24'd0, m4}, 32'd0);
        saved = done4_cnt;
        repeat (8) tick();
        check("abort_no_done", done4_cnt, saved);
        run4(1'b0, 4'd2, 4'd3, 8'd6);
        tick();

        // Early exit on the 8-bit instance
        run8(1'b0, 8'd200, 8'd3, 16'd600, 2);
        run8(1'b0, 8'd200, 8'd0, 16'd0, 1);
        run8(1'b0, 8'd200, 8'd128, 16'd25600, 8);
        run8(1'b1, 8'h80, 8'h80, 16'h4000, 8);
        run8(1'b1, 8'hFF, 8'd100, 16'hFF9C, 7);
        tick();

        // Random operands, mixing back-to-back starts and idle gaps
        for (int i = 0; i < 1000; i++) begin
            s  = 1'($urandom_range(0, 1));
            rx = 8'($urandom);
            ry = 8'($urandom);
            run8(s, rx, ry, ref8(s, rx, ry), lat8(s, ry));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) tick();
            end
        end

        repeat (3) tick();
        check("q4_drained", q4.size(), 32'd0);
        check("q8_drained", q8.size(), 32'd0);
        check("done8_vs_issued", done8_cnt, issued8);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
